// File: rtl/magnetron_pkg.sv
// Shared constants for the magnetron cook sequencer: FSM encoding and default sizing.
// Latency and backpressure: not applicable, this file holds definitions only.
package magnetron_pkg;
   localparam int DEF_TW       = 8;
   localparam int DEF_TICK_DIV = 100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_COOK  = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;
endpackage

// File: rtl/magnetron_seq_edge_det.sv
// Rising-edge detector for a synchronous button level; the pulse is combinational from d and the previous sample.
// Latency: same cycle as the rising level. No backpressure. A level held through reset never produces a pulse.
module edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);
   logic r_prev;
   logic r_armed;

   // r_armed stays low for the first cycle after reset so a held button is absorbed rather than seen as a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_prev  <= d;
         r_armed <= 1'b1;
      end
   end

   assign pulse = d & ~r_prev & r_armed;
endmodule

// File: rtl/magnetron_seq.sv
// Cook sequencer ahead of latch_sr: one-cycle s/r pulses, cook-time countdown, door interlock.
// Latency: outputs registered, one cycle after the deciding edge. No backpressure; button edges act immediately.
import magnetron_pkg::*;

module magnetron_seq #(
   parameter int TW       = DEF_TW,
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic          clear,
   input  logic          door_closed,
   input  logic          load_en,
   input  logic [TW-1:0] load_val,
   output logic          s,
   output logic          r,
   output logic          done,
   output logic [TW-1:0] remaining,
   output logic [1:0]    state
);
   localparam int             PW      = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_rem;
   logic [TW-1:0] w_rem_nxt;
   logic [PW-1:0] r_presc;
   logic [PW-1:0] w_presc_nxt;
   logic          r_s;
   logic          r_r;
   logic          r_done;
   logic          w_s_nxt;
   logic          w_r_nxt;
   logic          w_done_nxt;
   logic          w_start_e;
   logic          w_stop_e;
   logic          w_clear_e;
   logic          w_tick;

   edge_det u_start_ed (.clk(clk), .rst_n(rst_n), .d(start), .pulse(w_start_e));
   edge_det u_stop_ed  (.clk(clk), .rst_n(rst_n), .d(stop),  .pulse(w_stop_e));
   edge_det u_clear_ed (.clk(clk), .rst_n(rst_n), .d(clear), .pulse(w_clear_e));

   assign w_tick = (r_state == ST_COOK) && (r_presc == PS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem   <= '0;
         r_presc <= '0;
         r_s     <= 1'b0;
         r_r     <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_rem   <= w_rem_nxt;
         r_presc <= w_presc_nxt;
         r_s     <= w_s_nxt;
         r_r     <= w_r_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_presc_nxt = r_presc;
      w_s_nxt     = 1'b0;
      w_r_nxt     = 1'b0;
      w_done_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (load_en && (load_val != '0)) begin
               w_state_nxt = ST_READY;
               w_rem_nxt   = load_val;
            end
         end

         ST_READY: begin
            if (w_clear_e) begin
               w_state_nxt = ST_IDLE;
               w_rem_nxt   = '0;
            end else if (load_en) begin
               w_rem_nxt = load_val;
               if (load_val == '0) begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_start_e && door_closed) begin
               w_state_nxt = ST_COOK;
               w_s_nxt     = 1'b1;
               w_presc_nxt = '0;
            end
         end

         ST_COOK: begin
            w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
            // Door interlock outranks every button; r is the only way the latch is released.
            if (!door_closed) begin
               w_state_nxt = ST_PAUSE;
               w_r_nxt     = 1'b1;
            end else if (w_clear_e) begin
               w_state_nxt = ST_IDLE;
               w_rem_nxt   = '0;
               w_r_nxt     = 1'b1;
            end else if (w_stop_e) begin
               w_state_nxt = ST_PAUSE;
               w_r_nxt     = 1'b1;
            end else if (w_tick && (r_rem == TW'(1))) begin
               w_state_nxt = ST_IDLE;
               w_rem_nxt   = '0;
               w_r_nxt     = 1'b1;
               w_done_nxt  = 1'b1;
            end else if (w_tick && (r_rem != '0)) begin
               w_rem_nxt = r_rem - TW'(1);
            end
         end

         ST_PAUSE: begin
            if (w_clear_e) begin
               w_state_nxt = ST_IDLE;
               w_rem_nxt   = '0;
            end else if (w_start_e && door_closed) begin
               w_state_nxt = ST_COOK;
               w_s_nxt     = 1'b1;
               w_presc_nxt = '0;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign s         = r_s;
   assign r         = r_r;
   assign done      = r_done;
   assign remaining = r_rem;
   assign state     = r_state;
endmodule

// File: tb/tb_magnetron_seq.sv
// Directed and random bench for magnetron_seq at TW=8, TICK_DIV=4, with a behavioural latch_sr model on s/r.
module tb_magnetron_seq;
   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       clear;
   logic       door_closed;
   logic       load_en;
   logic [7:0] load_val;
   logic       s;
   logic       r;
   logic       done;
   logic [7:0] remaining;
   logic [1:0] state;
   logic       q;
   logic       prev_s;
   logic       prev_r;

   int n_tests = 0;
   int n_fail  = 0;

   magnetron_seq #(.TW(8), .TICK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
      .door_closed(door_closed), .load_en(load_en), .load_val(load_val),
      .s(s), .r(r), .done(done), .remaining(remaining), .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream set/reset latch.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= 1'b0;
      else if (s)  q <= 1'b1;
      else if (r)  q <= 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      prev_s = 1'b0;
      prev_r = 1'b0;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("s_and_r", {31'b0, s & r}, 32'd0);
         chk("s_width", {31'b0, s & prev_s}, 32'd0);
         chk("r_width", {31'b0, r & prev_r}, 32'd0);
      end
      prev_s = s;
      prev_r = r;
   end

   initial begin
      start = 0; stop = 0; clear = 0; door_closed = 1; load_en = 0; load_val = 0;
      rst_n = 1;
      // 1: asynchronous reset, checked before any clock edge
      #2 rst_n = 0;
      #1;
      chk("rst_s", {31'b0, s}, 0);
      chk("rst_r", {31'b0, r}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_state", {30'b0, state}, 0);
      chk("rst_rem", {24'b0, remaining}, 0);
      step(); step();
      rst_n = 1;
      step();

      // 2: full 3 s cook
      load_en = 1; load_val = 8'd3;
      step();
      load_en = 0;
      chk("t2_state_ready", {30'b0, state}, 1);
      chk("t2_rem_load", {24'b0, remaining}, 3);
      start = 1;
      step();
      start = 0;
      chk("t2_s", {31'b0, s}, 1);
      chk("t2_state_cook", {30'b0, state}, 2);
      step();
      chk("t2_s_low", {31'b0, s}, 0);
      chk("t2_q_on", {31'b0, q}, 1);
      for (int i = 2; i <= 11; i++) step();
      chk("t2_r_early", {31'b0, r}, 0);
      chk("t2_rem_1", {24'b0, remaining}, 1);
      step();
      chk("t2_r", {31'b0, r}, 1);
      chk("t2_done", {31'b0, done}, 1);
      chk("t2_state_idle", {30'b0, state}, 0);
      chk("t2_rem_0", {24'b0, remaining}, 0);
      step();
      chk("t2_r_low", {31'b0, r}, 0);
      chk("t2_done_low", {31'b0, done}, 0);
      chk("t2_q_off", {31'b0, q}, 0);

      // 3: door interlock
      load_en = 1; load_val = 8'd3;
      step();
      load_en = 0;
      start = 1;
      step();
      start = 0;
      chk("t3_s", {31'b0, s}, 1);
      for (int i = 0; i < 4; i++) step();
      chk("t3_rem_2", {24'b0, remaining}, 2);
      door_closed = 0;
      step();
      chk("t3_r", {31'b0, r}, 1);
      chk("t3_state_pause", {30'b0, state}, 3);
      chk("t3_rem_hold", {24'b0, remaining}, 2);
      step();
      chk("t3_r_low", {31'b0, r}, 0);
      start = 1;
      step();
      chk("t3_no_s_open", {31'b0, s}, 0);
      chk("t3_still_pause", {30'b0, state}, 3);
      start = 0;
      step();
      door_closed = 1; start = 1;
      step();
      start = 0;
      chk("t3_s_resume", {31'b0, s}, 1);
      chk("t3_state_cook", {30'b0, state}, 2);
      for (int i = 0; i < 7; i++) step();
      chk("t3_r_early", {31'b0, r}, 0);
      chk("t3_rem_1", {24'b0, remaining}, 1);
      step();
      chk("t3_r_end", {31'b0, r}, 1);
      chk("t3_done", {31'b0, done}, 1);
      chk("t3_state_idle", {30'b0, state}, 0);
      step();

      // 4: stop, then start+clear together, then zero load
      load_en = 1; load_val = 8'd5;
      step();
      load_en = 0;
      start = 1;
      step();
      start = 0;
      chk("t4_s", {31'b0, s}, 1);
      step();
      stop = 1;
      step();
      stop = 0;
      chk("t4_r_stop", {31'b0, r}, 1);
      chk("t4_state_pause", {30'b0, state}, 3);
      chk("t4_rem_hold", {24'b0, remaining}, 5);
      step();
      start = 1; clear = 1;
      step();
      start = 0; clear = 0;
      chk("t4_clear_state", {30'b0, state}, 0);
      chk("t4_clear_rem", {24'b0, remaining}, 0);
      chk("t4_clear_no_s", {31'b0, s}, 0);
      chk("t4_clear_no_r", {31'b0, r}, 0);
      step();
      load_en = 1; load_val = 8'd0;
      step();
      load_en = 0;
      chk("t4_zero_load", {30'b0, state}, 0);
      step();

      // 5: reset mid-cook with start held through reset
      load_en = 1; load_val = 8'd6;
      step();
      load_en = 0;
      start = 1;
      step();
      chk("t5_s", {31'b0, s}, 1);
      for (int i = 0; i < 4; i++) step();
      chk("t5_rem_5", {24'b0, remaining}, 5);
      #2 rst_n = 0;
      #1;
      chk("t5_rst_s", {31'b0, s}, 0);
      chk("t5_rst_r", {31'b0, r}, 0);
      chk("t5_rst_done", {31'b0, done}, 0);
      chk("t5_rst_state", {30'b0, state}, 0);
      chk("t5_rst_rem", {24'b0, remaining}, 0);
      step(); step();
      rst_n = 1;
      load_en = 1; load_val = 8'd4;
      step();
      load_en = 0;
      chk("t5_rel_s", {31'b0, s}, 0);
      chk("t5_rel_r", {31'b0, r}, 0);
      chk("t5_ready", {30'b0, state}, 1);
      step();
      chk("t5_held_no_s", {31'b0, s}, 0);
      step();
      chk("t5_held_ready", {30'b0, state}, 1);
      start = 0;
      step();
      start = 1;
      step();
      start = 0;
      chk("t5_repress_s", {31'b0, s}, 1);
      chk("t5_repress_cook", {30'b0, state}, 2);
      clear = 1;
      step();
      clear = 0;
      chk("t5_clear_r", {31'b0, r}, 1);
      chk("t5_clear_idle", {30'b0, state}, 0);
      step();

      // 6: random buttons and door; pulse properties checked by the negedge monitor
      for (int i = 0; i < 10000; i++) begin
         start       = ($urandom_range(0, 3) == 0);
         stop        = ($urandom_range(0, 7) == 0);
         clear       = ($urandom_range(0, 15) == 0);
         door_closed = ($urandom_range(0, 15) != 0);
         load_en     = ($urandom_range(0, 7) == 0);
         load_val    = 8'($urandom_range(0, 3));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
